hex_scan_display: RTL and testbench
===================================

Name: hex_scan_display

Overview:
Time-multiplexed driver for an N-digit common-anode seven-segment bank sharing one segment bus. It latches a packed hex word, scans the digits round-robin with dead time between them, and applies PWM brightness. It also provides per-digit decimal points and optional leading-zero blanking. It sits between the top-level debug/score registers and the board display pins, replacing per-digit static decoders.

Parameters:
NUM_DIGITS, 4, digits scanned; 1..8.
SLOT_CYCLES, 50000, clock cycles per digit slot; multiple of 16, ≥32.
DEAD_CYCLES, 64, cycles at the start of each slot with all anodes off (anti-ghosting); < SLOT_CYCLES/2.

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous, active-low reset
value  in  4*NUM_DIGITS  packed hex digits; nibble 0 = rightmost
dp  in  NUM_DIGITS  decimal-point request per digit, 1 = lit
load  in  1  1-cycle strobe: capture value/dp into pending register
lz_blank  in  1  1 = suppress leading zeros
brightness  in  4  duty level 0..15
seg_n  out  7  segments {g..a}, active-low
dp_n  out  1  decimal point, active-low
an_n  out  NUM_DIGITS  digit anodes, active-low, at most one low
frame_done  out  1  1-cycle pulse at end of last digit slot

Behaviour:
- Reset (Reset_n=0 at a Clk edge): seg_n=7'h7F, dp_n=1, an_n=all 1, frame_done=0, digit index=0, slot counter=0, pending and active registers=0, pending_valid=0, FSM=DEAD.
- Load: load=1 captures value/dp into pending and sets pending_valid; a later load before transfer overwrites.
- Tear-free update: pending is copied to active only on the cycle the slot counter wraps from the last digit back to digit 0 (same cycle frame_done asserts); pending_valid clears. Load coinciding with transfer: new data goes to pending, pending_valid stays 1, and the old pending moves to active.
- Slot counter 0..SLOT_CYCLES-1; at SLOT_CYCLES-1 it wraps to 0 and the digit index advances (NUM_DIGITS-1 → 0).
- FSM: DEAD while counter < DEAD_CYCLES (an_n all 1, seg_n=7'h7F, dp_n=1); then DRIVE for the rest of the slot; wrap → DEAD.
- PWM in DRIVE: phase = counter / (SLOT_CYCLES/16); anode asserted only while phase < brightness. brightness=0 → display dark; 15 → lit 15/16 of the slot minus dead time. brightness is sampled every cycle (no latching).
- Decode: standard hex glyphs 0-F (0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E, active-low).
- Leading-zero blanking (lz_blank=1): digit i is blanked (seg_n=7'h7F, anode still follows PWM) if every nibble from i upward is 0. Digit 0 is never blanked. dp of a blanked digit is still honoured.
- Outputs are registered: seg_n/dp_n/an_n reflect the counter and index state of the previous cycle (1-cycle latency). Segment and anode changes occur on the same edge, and DEAD guarantees no overlap.
- frame_done: high for exactly the one cycle following the wrap of digit NUM_DIGITS-1.
- Reset mid-slot: outputs go to reset values on that edge; the scan restarts at digit 0 in DEAD.

Decomposition:
- Package hex_display_pkg: scan_state_t enum {DEAD, DRIVE}; SEG_BLANK=7'h7F; 16-entry glyph constant table.
- Sub-module seg7_decode: combinational nibble→active-low 7-segment using the package table. Instantiate once, muxed by digit index.

Test Plan:
- NUM_DIGITS=4, SLOT_CYCLES=32, DEAD_CYCLES=2, brightness=15; load value=16'h12AF after reset → digit 0 shows 7'h0E (F) with an_n=4'b1110 from cycle 3 of slot, then digit 1 shows 7'h08, digit 2 shows 7'h24, digit 3 shows 7'h79. Verify an_n all 1 for 2 cycles at each slot start.
- lz_blank=1, value=16'h0005 → digits 3..1 output seg_n=7'h7F, digit 0 shows 7'h12; value=16'h0000 → digit 0 shows 7'h40, others blank.
- Load 16'h1111, then load 16'h2222 mid-frame → active changes only at the frame_done cycle, which jumps straight to 2222; no digit of a single frame shows mixed data.
- brightness=0 → an_n stays all 1 for a full frame; brightness=8 → each anode low for exactly 14 cycles per slot (phases 0-7 = 16 cycles, minus 2 dead cycles).
- dp=4'b0100 → dp_n=0 only during digit 2 DRIVE. frame_done pulses once every 128 cycles.
- Assert Reset_n=0 mid-slot of digit 2 → next edge: an_n=all 1, seg_n=7'h7F, active=0; after release the scan restarts at digit 0.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multiplexed hex display driver.
package hex_display_pkg;

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_scan_display_seg7_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module seg7_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n_c
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    o_seg_n_c = GLYPH[i_nibble];
  end

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed N-digit common-anode seven-segment driver with dead time,
// PWM brightness, decimal points, leading-zero blanking and tear-free updates.
module hex_scan_display
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SLOT_CYCLES = 50000,
  parameter int unsigned DEAD_CYCLES = 64
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int unsigned VAL_W  = 4 * NUM_DIGITS;
  localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W  = $clog2(SLOT_CYCLES);
  localparam int unsigned PH_LEN = SLOT_CYCLES / 16;
  localparam int unsigned SUB_W  = $clog2(PH_LEN);

  scan_state_t            r_state;
  scan_state_t            w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [SUB_W-1:0]       r_sub;
  logic [3:0]             r_phase;
  logic [DIG_W-1:0]       r_digit;
  logic [VAL_W-1:0]       r_pend_val;
  logic [NUM_DIGITS-1:0]  r_pend_dp;
  logic                   r_pend_valid;
  logic [VAL_W-1:0]       r_act_val;
  logic [NUM_DIGITS-1:0]  r_act_dp;

  logic                   w_slot_end;
  logic                   w_sub_end;
  logic                   w_frame_end;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [3:0]             w_nibble;
  logic                   w_dp_sel;
  logic                   w_blank;
  logic                   w_zero_run;
  logic [6:0]             w_glyph;
  logic [6:0]             w_seg_n;
  logic                   w_dp_n;
  logic [NUM_DIGITS-1:0]  w_an_n;

  // Slot and frame boundary detection.
  always_comb begin
    w_slot_end  = (r_cnt == CNT_W'(SLOT_CYCLES - 1));
    w_sub_end   = (r_sub == SUB_W'(PH_LEN - 1));
    w_frame_end = w_slot_end && (r_digit == DIG_W'(NUM_DIGITS - 1));
    w_cnt_next  = w_slot_end ? '0 : r_cnt + CNT_W'(1);
  end

  // Select the active digit's nibble/dp and evaluate leading-zero blanking.
  always_comb begin
    w_nibble   = 4'h0;
    w_dp_sel   = 1'b0;
    w_blank    = 1'b0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (r_act_val[4*i +: 4] == 4'h0);
      if (r_digit == DIG_W'(i)) begin
        w_nibble = r_act_val[4*i +: 4];
        w_dp_sel = r_act_dp[i];
        w_blank  = lz_blank && w_zero_run && (i != 0);
      end
    end
  end

  seg7_decode u_seg7_decode (
    .i_nibble  (w_nibble),
    .o_seg_n_c (w_glyph)
  );

  // FSM next state and next values of the registered display outputs.
  always_comb begin
    w_state_next = r_state;
    w_seg_n      = SEG_BLANK;
    w_dp_n       = 1'b1;
    w_an_n       = '1;
    if (w_cnt_next < CNT_W'(DEAD_CYCLES)) begin
      w_state_next = DEAD;
    end else begin
      w_state_next = DRIVE;
    end
    if (r_state == DRIVE) begin
      w_seg_n = w_blank ? SEG_BLANK : w_glyph;
      w_dp_n  = ~w_dp_sel;
      if (r_phase < brightness) begin
        w_an_n = ~(NUM_DIGITS'(1) << r_digit);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= DEAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Slot counter, PWM phase counter and digit index.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_cnt   <= '0;
      r_sub   <= '0;
      r_phase <= 4'h0;
      r_digit <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_slot_end) begin
        r_sub   <= '0;
        r_phase <= 4'h0;
        r_digit <= (r_digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_digit + DIG_W'(1);
      end else if (w_sub_end) begin
        r_sub   <= '0;
        r_phase <= r_phase + 4'h1;
      end else begin
        r_sub <= r_sub + SUB_W'(1);
      end
    end
  end

  // Pending capture on load; pending moves to active only at frame end.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
    end else begin
      if (load) begin
        r_pend_val   <= value;
        r_pend_dp    <= dp;
        r_pend_valid <= 1'b1;
      end else if (w_frame_end) begin
        r_pend_valid <= 1'b0;
      end
      if (w_frame_end && r_pend_valid) begin
        r_act_val <= r_pend_val;
        r_act_dp  <= r_pend_dp;
      end
    end
  end

  // Registered display pins and frame pulse.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= w_seg_n;
      dp_n       <= w_dp_n;
      an_n       <= w_an_n;
      frame_done <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed self-checking bench for hex_scan_display (4 digits, 32-cycle slots).
module tb_hex_scan_display;

  logic        Clk;
  logic        Reset_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        lz_blank;
  logic [3:0]  brightness;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  hex_scan_display #(
    .NUM_DIGITS  (4),
    .SLOT_CYCLES (32),
    .DEAD_CYCLES (2)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .value      (value),
    .dp         (dp),
    .load       (load),
    .lz_blank   (lz_blank),
    .brightness (brightness),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // One clock: active edge, then sample point on the falling edge.
  task automatic tick();
    @(posedge Clk);
    cyc++;
    @(negedge Clk);
  endtask

  // Advance until the outputs reflect global scan cycle g.
  task automatic wait_to(input int g);
    while (cyc < g + 1) tick();
  endtask

  // Present a load strobe on the edge that processes scan cycle g.
  task automatic do_load(input int g, input logic [15:0] v, input logic [3:0] d);
    while (cyc < g) tick();
    value = v;
    dp    = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int low_cnt [4];
  int bad_an, dp_in2, dp_out, fd_cnt, fd_bad, lit;
  int slot;

  initial begin
    Reset_n    = 1'b0;
    value      = 16'h0;
    dp         = 4'h0;
    load       = 1'b0;
    lz_blank   = 1'b0;
    brightness = 4'd15;
    tick();
    tick();
    check("rst_seg", 16'(seg_n), 16'h7F);
    check("rst_dp", 16'(dp_n), 16'h1);
    check("rst_an", 16'(an_n), 16'hF);
    check("rst_fd", 16'(frame_done), 16'h0);

    // Release and load 12AF on the first scan cycle.
    Reset_n = 1'b1;
    value   = 16'h12AF;
    load    = 1'b1;
    cyc     = 0;
    tick();
    load = 1'b0;
    check("f0_dead0_an", 16'(an_n), 16'hF);
    check("f0_dead0_fd", 16'(frame_done), 16'h0);
    wait_to(1);   check("f0_dead1_an", 16'(an_n), 16'hF);
    wait_to(2);   check("f0_d0_an", 16'(an_n), 16'hE);
    check("f0_d0_seg_old", 16'(seg_n), 16'h40);
    wait_to(126); check("f0_fd_early", 16'(frame_done), 16'h0);
    wait_to(127); check("f0_fd_pulse", 16'(frame_done), 16'h1);
    wait_to(128); check("f1_fd_drop", 16'(frame_done), 16'h0);
    check("f1_dead0_an", 16'(an_n), 16'hF);
    wait_to(129); check("f1_dead1_an", 16'(an_n), 16'hF);
    wait_to(130); check("f1_d0_an", 16'(an_n), 16'hE);
    check("f1_d0_seg", 16'(seg_n), 16'h0E);
    wait_to(157); check("f1_d0_pwm_on", 16'(an_n), 16'hE);
    wait_to(158); check("f1_d0_pwm_off", 16'(an_n), 16'hF);
    wait_to(160); check("f1_s1_dead0", 16'(an_n), 16'hF);
    wait_to(161); check("f1_s1_dead1", 16'(an_n), 16'hF);
    wait_to(162); check("f1_d1_an", 16'(an_n), 16'hD);
    check("f1_d1_seg", 16'(seg_n), 16'h08);
    wait_to(194); check("f1_d2_an", 16'(an_n), 16'hB);
    check("f1_d2_seg", 16'(seg_n), 16'h24);
    wait_to(226); check("f1_d3_an", 16'(an_n), 16'h7);
    check("f1_d3_seg", 16'(seg_n), 16'h79);

    // Leading-zero blanking.
    lz_blank = 1'b1;
    do_load(230, 16'h0005, 4'h0);
    wait_to(258); check("lz5_d0_seg", 16'(seg_n), 16'h12);
    wait_to(290); check("lz5_d1_seg", 16'(seg_n), 16'h7F);
    check("lz5_d1_an", 16'(an_n), 16'hD);
    wait_to(322); check("lz5_d2_seg", 16'(seg_n), 16'h7F);
    wait_to(354); check("lz5_d3_seg", 16'(seg_n), 16'h7F);
    do_load(360, 16'h0000, 4'h0);
    wait_to(386); check("lz0_d0_seg", 16'(seg_n), 16'h40);

    // Tear-free update: two loads within one frame.
    do_load(400, 16'h1111, 4'h0);
    wait_to(418); check("tear_d1_seg", 16'(seg_n), 16'h7F);
    wait_to(450); check("tear_d2_seg", 16'(seg_n), 16'h7F);
    do_load(460, 16'h2222, 4'h0);
    wait_to(482); check("tear_d3_seg", 16'(seg_n), 16'h7F);
    wait_to(514); check("upd_d0_seg", 16'(seg_n), 16'h24);
    do_load(600, 16'h3333, 4'h0);
    wait_to(610); check("upd_d3_seg", 16'(seg_n), 16'h24);

    // Load on the transfer edge: old pending shown, new pending kept.
    do_load(639, 16'h4444, 4'h0);
    wait_to(642); check("coin_f5_seg", 16'(seg_n), 16'h30);
    wait_to(770); check("coin_f6_seg", 16'(seg_n), 16'h19);

    // Brightness 0: dark for a whole frame; dp pattern loaded meanwhile.
    wait_to(895);
    brightness = 4'd0;
    value      = 16'h4444;
    dp         = 4'b0100;
    lit        = 0;
    for (int g = 896; g < 1024; g++) begin
      load = (g == 1000);
      tick();
      if (an_n !== 4'hF) lit++;
    end
    load = 1'b0;
    check("b0_lit_cycles", 16'(lit), 16'd0);

    // Brightness 8 plus decimal point on digit 2.
    brightness = 4'd8;
    bad_an = 0; dp_in2 = 0; dp_out = 0; fd_cnt = 0; fd_bad = 0;
    for (int d = 0; d < 4; d++) low_cnt[d] = 0;
    for (int g = 1024; g < 1152; g++) begin
      tick();
      slot = (g - 1024) / 32;
      for (int d = 0; d < 4; d++) if (an_n[d] === 1'b0) low_cnt[d]++;
      if (an_n !== 4'hF && an_n !== ~(4'b0001 << slot)) bad_an++;
      if (dp_n === 1'b0) begin
        if (slot == 2) dp_in2++;
        else dp_out++;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (g != 1151) fd_bad++;
      end
    end
    check("b8_low_d0", 16'(low_cnt[0]), 16'd14);
    check("b8_low_d1", 16'(low_cnt[1]), 16'd14);
    check("b8_low_d2", 16'(low_cnt[2]), 16'd14);
    check("b8_low_d3", 16'(low_cnt[3]), 16'd14);
    check("b8_an_onehot", 16'(bad_an), 16'd0);
    check("dp_d2_cycles", 16'(dp_in2), 16'd30);
    check("dp_other_cycles", 16'(dp_out), 16'd0);
    check("fd_count", 16'(fd_cnt), 16'd1);
    check("fd_position", 16'(fd_bad), 16'd0);

    // Reset in the middle of digit 2.
    brightness = 4'd15;
    wait_to(1220);
    check("pre_rst_an", 16'(an_n), 16'hB);
    Reset_n = 1'b0;
    tick();
    check("mid_rst_an", 16'(an_n), 16'hF);
    check("mid_rst_seg", 16'(seg_n), 16'h7F);
    check("mid_rst_dp", 16'(dp_n), 16'h1);
    check("mid_rst_fd", 16'(frame_done), 16'h0);
    Reset_n = 1'b1;
    cyc     = 0;
    tick();
    check("rr_dead0_an", 16'(an_n), 16'hF);
    wait_to(2);   check("rr_d0_an", 16'(an_n), 16'hE);
    check("rr_d0_seg", 16'(seg_n), 16'h40);
    check("rr_d0_dp", 16'(dp_n), 16'h1);
    wait_to(34);  check("rr_d1_an", 16'(an_n), 16'hD);
    check("rr_d1_seg", 16'(seg_n), 16'h7F);
    wait_to(130); check("rr_f1_d0_seg", 16'(seg_n), 16'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
